// File: rtl/ip_header_tx_if.sv
// ----------------------------------------------------------------------------
// ip_header_tx_if
// Purpose : groups the request inputs and the byte-stream outputs of
//           ip_header_tx into one bundle.
// Signals : start          - one-cycle request to emit one IPv4 header
//           udp_len        - UDP length in bytes (UDP header plus payload)
//           ip_s_addr      - source IPv4 address
//           ip_d_addr      - destination IPv4 address
//           data_out       - header byte, MSB-first per field
//           data_valid     - data_out holds a valid byte
//           data_ready     - downstream accepts data_out this cycle
//           busy           - header generator is not idle
//           ip_header_done - one-cycle pulse after the last byte transfers
// Modports: slave  - the header generator
//           master - the requester / downstream sink
// ----------------------------------------------------------------------------
interface ip_header_tx_if;
    logic        start;
    logic [15:0] udp_len;
    logic [31:0] ip_s_addr;
    logic [31:0] ip_d_addr;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        ip_header_done;

    modport slave (
        input  start, udp_len, ip_s_addr, ip_d_addr, data_ready,
        output data_out, data_valid, busy, ip_header_done
    );

    modport master (
        output start, udp_len, ip_s_addr, ip_d_addr, data_ready,
        input  data_out, data_valid, busy, ip_header_done
    );
endinterface

// File: rtl/ip_header_tx.sv
// ----------------------------------------------------------------------------
// ip_header_tx
// Purpose : builds a 20-byte IPv4 header (protocol UDP) and streams it out
//           one byte per accepted transfer. The header checksum is computed
//           serially: 10 cycles summing 16-bit words into a 20-bit
//           accumulator, then 2 end-around-carry folds.
// Params  : TTL     - time-to-live byte placed at header offset 8
//           ID_INIT - identification value after reset
// Ports   : aclk    - clock, rising edge
//           areset  - synchronous active-high reset
//           hdr     - ip_header_tx_if.slave (request inputs, byte stream out)
// ----------------------------------------------------------------------------
module ip_header_tx #(
    parameter logic [7:0]  TTL     = 8'hFF,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic          aclk,
    input  logic          areset,
    ip_header_tx_if.slave hdr
);

    typedef enum logic [1:0] {IDLE, CALC, FOLD, SEND} state_t;

    state_t      state_q;
    logic [4:0]  idx_q;        // CALC word index, FOLD step, SEND byte index
    logic [19:0] acc_q;
    logic [15:0] id_q;         // identification for the next header
    logic [15:0] hdr_id_q;     // identification of the header in progress
    logic [15:0] tot_len_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        busy_q;
    logic        done_q;

    logic [19:0] acc_add_d;
    logic [19:0] acc_fold_d;

    // Header word w (0..9) with the checksum word (5) taken as zero.
    function automatic logic [15:0] hdr_word(input logic [3:0] w);
        case (w)
            4'd0:    hdr_word = 16'h4500;
            4'd1:    hdr_word = tot_len_q;
            4'd2:    hdr_word = hdr_id_q;
            4'd4:    hdr_word = {TTL, 8'h11};
            4'd6:    hdr_word = src_q[31:16];
            4'd7:    hdr_word = src_q[15:0];
            4'd8:    hdr_word = dst_q[31:16];
            4'd9:    hdr_word = dst_q[15:0];
            default: hdr_word = 16'h0000;
        endcase
    endfunction

    // Header byte b (0..19); bytes 10/11 carry the folded, inverted sum.
    // Only valid in SEND, once acc_q holds its final folded value.
    function automatic logic [7:0] hdr_byte(input logic [4:0] b);
        logic [15:0] w;
        w = (b[4:1] == 4'd5) ? ~acc_q[15:0] : hdr_word(b[4:1]);
        hdr_byte = b[0] ? w[7:0] : w[15:8];
    endfunction

    assign acc_add_d  = acc_q + {4'h0, hdr_word(idx_q[3:0])};
    assign acc_fold_d = {4'h0, acc_q[15:0]} + {16'h0000, acc_q[19:16]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            idx_q        <= 5'd0;
            acc_q        <= 20'd0;
            id_q         <= ID_INIT;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hdr.start) begin
                        // Snapshot everything the header depends on so later
                        // input changes cannot disturb it.
                        tot_len_q <= hdr.udp_len + 16'd20;
                        src_q     <= hdr.ip_s_addr;
                        dst_q     <= hdr.ip_d_addr;
                        hdr_id_q  <= id_q;
                        acc_q     <= 20'd0;
                        idx_q     <= 5'd0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_add_d;
                    if (idx_q == 5'd9) begin
                        idx_q   <= 5'd0;
                        state_q <= FOLD;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                FOLD: begin
                    // Ten 16-bit words sum to at most 0x9FFF6, so two folds
                    // always leave the carry nibble at zero.
                    acc_q <= acc_fold_d;
                    if (idx_q == 5'd1) begin
                        idx_q        <= 5'd0;
                        state_q      <= SEND;
                        data_valid_q <= 1'b1;
                        data_out_q   <= hdr_byte(5'd0);
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                SEND: begin
                    if (hdr.data_ready) begin
                        if (idx_q == 5'd19) begin
                            idx_q        <= 5'd0;
                            state_q      <= IDLE;
                            data_valid_q <= 1'b0;
                            data_out_q   <= 8'h00;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            id_q         <= id_q + 16'd1;
                        end else begin
                            idx_q      <= idx_q + 5'd1;
                            data_out_q <= hdr_byte(idx_q + 5'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hdr.data_out       = data_out_q;
    assign hdr.data_valid     = data_valid_q;
    assign hdr.busy           = busy_q;
    assign hdr.ip_header_done = done_q;

endmodule

// File: tb/tb_ip_header_tx.sv
// ----------------------------------------------------------------------------
// tb_ip_header_tx
// Purpose : self-checking bench for ip_header_tx. A driver issues header
//           requests and queues the expected bytes (from a byte-level
//           reference model or literal header images); a monitor pops and
//           compares every transferred byte. A separate process shapes
//           data_ready (always high, fixed stall pattern, or random).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ip_header_tx;

    localparam logic [7:0]  TTL_P     = 8'hFF;
    localparam logic [15:0] ID_INIT_P = 16'hFFFF;

    logic aclk = 1'b0;
    logic areset;

    ip_header_tx_if bus();

    ip_header_tx #(.TTL(TTL_P), .ID_INIT(ID_INIT_P)) dut (
        .aclk   (aclk),
        .areset (areset),
        .hdr    (bus)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    int          len_q[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    int          mon_cnt  = 0;     // bytes transferred in the current header
    int          ready_mode = 0;   // 0: always ready, 1: stall pattern, 2: random
    logic [15:0] exp_id;

    // Header image for udp_len=005F, src=C0A80001, dst=C0A800C7, ID=0000.
    logic [7:0] basic_bytes [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'hFF, 8'h11, 8'h39, 8'h61,
                                     8'hC0, 8'hA8, 8'h00, 8'h01,
                                     8'hC0, 8'hA8, 8'h00, 8'hC7};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: lay out the header bytes, sum big-endian 16-bit words with
    // end-around carry until it fits, complement into bytes 10/11.
    function automatic void model_push(input logic [15:0] len, input logic [31:0] s,
                                       input logic [31:0] d, input logic [15:0] id);
        logic [7:0]  b [20];
        logic [15:0] tl;
        logic [15:0] cs;
        int          sum;
        tl = len + 16'd20;
        b = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h00, 8'h00,
              TTL_P, 8'h11, 8'h00, 8'h00, s[31:24], s[23:16], s[15:8], s[7:0],
              d[31:24], d[23:16], d[15:8], d[7:0]};
        sum = 0;
        for (int i = 0; i < 20; i += 2) sum += int'({b[i], b[i+1]});
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        b[10] = cs[15:8];
        b[11] = cs[7:0];
        for (int i = 0; i < 20; i++) exp_q.push_back(b[i]);
    endfunction

    // data_ready shaping, updated just after each rising edge.
    initial begin
        int stall = 0;
        int last  = 0;
        bus.data_ready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (mon_cnt != last) stall = 0;
            last = mon_cnt;
            case (ready_mode)
                1: begin
                    if (bus.data_valid && (mon_cnt == 0 || mon_cnt == 10 || mon_cnt == 19)
                        && stall < 3) begin
                        bus.data_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.data_ready = 1'b1;
                    end
                end
                2:       bus.data_ready = ($urandom_range(3) != 0);
                default: bus.data_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_d     = 8'h00;
        int         send_len   = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                mon_cnt    = 0;
                send_len   = 0;
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", int'(bus.data_valid), 1);
                check("hold_data", int'(bus.data_out), int'(prev_d));
            end
            if (!bus.data_valid) check("idle_data_zero", int'(bus.data_out), 0);
            else                 check("valid_implies_busy", int'(bus.busy), 1);
            if (bus.data_valid) send_len++;
            if (bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no transfer", bus.data_out);
                end else begin
                    check("byte", int'(bus.data_out), int'(exp_q.pop_front()));
                end
                mon_cnt = (mon_cnt + 1) % 20;
            end
            prev_stall = bus.data_valid && !bus.data_ready;
            prev_d     = bus.data_out;
            if (bus.ip_header_done) begin
                done_cnt++;
                check("done_valid_low", int'(bus.data_valid), 0);
                check("done_busy_low", int'(bus.busy), 0);
                check("done_after_byte19", mon_cnt, 0);
                if (len_q.size() > 0) begin
                    int l;
                    l = len_q.pop_front();
                    if (l != 0) check("send_len", send_len, l);
                end
                send_len = 0;
            end
        end
    end

    // variant: 0 model, 1 basic image (ID 0000), 2 basic image with ID 0001
    task automatic issue(input logic [15:0] len, input logic [31:0] s, input logic [31:0] d,
                         input int variant, input int slen, input bit disturb);
        int n;
        bus.udp_len   = len;
        bus.ip_s_addr = s;
        bus.ip_d_addr = d;
        bus.start     = 1'b1;
        if (variant == 0) begin
            model_push(len, s, d, exp_id);
        end else begin
            for (int i = 0; i < 20; i++) begin
                if (variant == 2 && i == 5)       exp_q.push_back(8'h01);
                else if (variant == 2 && i == 11) exp_q.push_back(8'h60);
                else                              exp_q.push_back(basic_bytes[i]);
            end
        end
        len_q.push_back(slen);
        exp_id = exp_id + 16'd1;
        @(posedge aclk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.data_valid && n < 40) begin
            @(negedge aclk);
            n++;
            if (disturb && n == 4) begin
                bus.start     = 1'b1;
                bus.udp_len   = 16'($urandom);
                bus.ip_s_addr = $urandom;
                bus.ip_d_addr = $urandom;
            end
            if (disturb && n == 5) bus.start = 1'b0;
        end
        check("first_valid_cycle", n, 13);
        if (disturb) begin
            repeat (3) @(negedge aclk);
            bus.start     = 1'b1;
            bus.udp_len   = 16'($urandom);
            bus.ip_s_addr = $urandom;
            bus.ip_d_addr = $urandom;
            @(negedge aclk);
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.ip_header_done && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (!bus.ip_header_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected a done pulse", name, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.start     = 1'b0;
        bus.udp_len   = 16'h0000;
        bus.ip_s_addr = 32'h0;
        bus.ip_d_addr = 32'h0;
        exp_id        = ID_INIT_P;
        areset        = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.ip_header_done), 0);
        check("rst_data", int'(bus.data_out), 0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        // Length wrap and ID_INIT=FFFF.
        issue(16'hFFF0, $urandom, $urandom, 0, 20, 1'b0);
        exp_done++;
        wait_done("wrap");
        repeat (3) @(negedge aclk);

        // Basic header (ID wrapped to 0000), then back-to-back on the done cycle.
        issue(16'h005F, 32'hC0A80001, 32'hC0A800C7, 1, 20, 1'b0);
        exp_done++;
        wait_done("basic");
        issue(16'h005F, 32'hC0A80001, 32'hC0A800C7, 2, 20, 1'b0);
        exp_done++;
        wait_done("back_to_back");
        repeat (2) @(negedge aclk);

        // Backpressure on bytes 0, 10 and 19.
        ready_mode = 1;
        issue(16'h005F, 32'hC0A80001, 32'hC0A800C7, 0, 29, 1'b0);
        exp_done++;
        wait_done("backpressure");
        ready_mode = 0;
        repeat (2) @(negedge aclk);

        // Ignored start and input changes while busy.
        issue(16'($urandom), $urandom, $urandom, 0, 20, 1'b1);
        exp_done++;
        wait_done("ignored_start");
        repeat (20) @(negedge aclk);
        check("single_done", done_cnt, exp_done);

        // Random headers under random backpressure, sometimes back-to-back.
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            issue(16'($urandom), $urandom, $urandom, 0, 0, 1'b0);
            exp_done++;
            wait_done("random");
            if ($urandom_range(1) == 0) repeat ($urandom_range(3)) @(negedge aclk);
        end
        ready_mode = 0;
        repeat (3) @(negedge aclk);

        // Reset after byte 7 transfers.
        issue(16'($urandom), $urandom, $urandom, 0, 20, 1'b0);
        n = 0;
        while (mon_cnt != 8 && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        check("reached_byte8", mon_cnt, 8);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("midrst_valid", int'(bus.data_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.ip_header_done), 0);
        check("midrst_data", int'(bus.data_out), 0);
        exp_q.delete();
        len_q.delete();
        exp_id = ID_INIT_P;
        repeat (5) @(negedge aclk);
        check("midrst_no_resume", int'(bus.busy), 0);
        issue(16'h0123, 32'h0A000001, 32'h0A000002, 0, 20, 1'b0);
        exp_done++;
        wait_done("after_reset");

        repeat (10) @(negedge aclk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_header_tx.md
IP_HEADER_TX -- requirements
Module: ip_header_tx

Interface
REQ-001 The block SHALL have parameter TTL, default 8'hFF, time-to-live byte inserted at header offset 8.
REQ-002 The block SHALL have parameter ID_INIT, default 16'h0000, identification value after reset.
REQ-003 The block SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port areset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to emit one header.
REQ-006 The block SHALL have port udp_len, input, 16, UDP length in bytes (UDP header plus payload).
REQ-007 The block SHALL have port ip_s_addr, input, 32, source IPv4 address.
REQ-008 The block SHALL have port ip_d_addr, input, 32, destination IPv4 address.
REQ-009 The block SHALL have port data_out, output, 8, header byte, MSB-first per field.
REQ-010 The block SHALL have port data_valid, output, 1, data_out holds a valid byte.
REQ-011 The block SHALL have port data_ready, input, 1, downstream accepts data_out this cycle.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port ip_header_done, output, 1, one-cycle pulse after the last byte transfers.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FOLD, SEND.
REQ-015 In IDLE, start=1 SHALL latch udp_len, ip_s_addr, ip_d_addr and the current ID, then move to CALC; start outside IDLE SHALL be ignored.
REQ-016 Header bytes 0..19 SHALL be 45, 00, total_len[15:8], total_len[7:0], id[15:8], id[7:0], 00, 00, TTL, 11, csum[15:8], csum[7:0], src[31:0], dst[31:0].
REQ-017 total_len SHALL equal udp_len + 20, taken modulo 2^16 with no saturation or error flag.
REQ-018 CALC SHALL last exactly 10 cycles and add one 16-bit header word per cycle (words 0..9, checksum word as 0) into a 20-bit accumulator cleared on entry.
REQ-019 FOLD SHALL last exactly 2 cycles, each applying acc = acc[15:0] + acc[19:16]; csum SHALL then equal ~acc[15:0].
REQ-020 SEND SHALL be entered 13 cycles after the start-accept edge with data_valid=1 and byte 0 on data_out.
REQ-021 A byte SHALL transfer only on a cycle with data_valid=1 and data_ready=1; the byte index advances only on a transfer.
REQ-022 While data_ready=0 in SEND, data_out and data_valid SHALL hold stable.
REQ-023 data_valid SHALL be 0 outside SEND, and data_out SHALL be 8'h00 whenever data_valid=0.
REQ-024 On transfer of byte 19, the FSM SHALL return to IDLE, and the next cycle SHALL have ip_header_done=1, data_valid=0 and busy=0.
REQ-025 The ID register SHALL increment by 1, wrapping 16'hFFFF to 16'h0000, on each byte-19 transfer.
REQ-026 start in the same cycle as ip_header_done=1 SHALL be accepted, and the new header SHALL use the incremented ID.
REQ-027 Input changes after the start-accept edge SHALL NOT affect the header in progress.

Reset
REQ-028 areset=1 SHALL force IDLE, set data_valid=0, busy=0, ip_header_done=0, data_out=8'h00, byte index=0, accumulator=0, and ID=ID_INIT on the next edge.
REQ-029 Reset SHALL take priority over start and data_ready, including mid-CALC and mid-SEND; a partial header SHALL NOT resume after reset.

Verification
REQ-030 Basic header: start with udp_len=16'h005F, src=C0A80001, dst=C0A800C7, ready held high -> bytes 45 00 00 73 00 00 00 00 FF 11 39 61 C0 A8 00 01 C0 A8 00 C7; data_valid first high 13 cycles after start; done pulses once.
REQ-031 Back-to-back: repeat REQ-030 with start asserted on the done cycle -> second header has ID 00 01 and csum 39 60.
REQ-032 Backpressure: data_ready low for 3 cycles at bytes 0, 10 and 19 -> each byte held stable; output identical to REQ-030; total SEND length 29 cycles.
REQ-033 Ignored start and input change: pulse start and change all inputs during CALC and SEND -> header unchanged; exactly one done pulse.
REQ-034 Wrap: udp_len=16'hFFF0 -> total_len bytes 00 04; ID_INIT=16'hFFFF -> ID FF FF, next header ID 00 00; csum checked against a reference model.
REQ-035 Reset mid-SEND: areset high after byte 7 transfers -> next cycle data_valid=0, busy=0; a new start then produces a full 20-byte header with ID=ID_INIT.
